thor2024_rfwr_arb: RTL and testbench

THOR2024_RFWR_ARB -- requirements
Module: Thor2024_rfwr_arb

---
 rtl/thor2024_rfwr_arb_pkg.sv | 12 +
 rtl/thor2024_rfwr_arb_rr_pick2.sv | 43 ++++
 rtl/thor2024_rfwr_arb.sv | 126 ++++++++++++
 tb/tb_thor2024_rfwr_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/thor2024_rfwr_arb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// The optional statistics counters are enabled with THOR2024_RFWR_STATS_EN.
package thor2024_rfwr_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int REG_W        = 6;
    localparam int VALUE_W      = 64;

    typedef logic [REG_W-1:0]   reg_idx_t;
    typedef logic [VALUE_W-1:0] value_t;

endpackage

// File: rtl/thor2024_rfwr_arb_rr_pick2.sv
// Circular two-pick selector: port 0 takes the first valid requester from rr_ptr,
// port 1 takes the next one whose target differs (target 0 may pair with target 0).
module thor2024_rfwr_arb_rr_pick2
    import thor2024_rfwr_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]            valid,
    input  reg_idx_t [NREQ-1:0]        tgt,
    input  logic [PTR_W-1:0]           rr_ptr,
    output logic [NREQ-1:0]            grant0,
    output logic [NREQ-1:0]            grant1
);

    logic     have0;
    logic     have1;
    reg_idx_t tgt0;

    // Outer loop walks scan positions; inner loop finds the requester at that position.
    always_comb begin
        grant0 = '0;
        grant1 = '0;
        have0  = 1'b0;
        have1  = 1'b0;
        tgt0   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (i == (32'(rr_ptr) + k) % NREQ && valid[PTR_W'(i)]) begin
                    if (!have0) begin
                        grant0[PTR_W'(i)] = 1'b1;
                        have0             = 1'b1;
                        tgt0              = tgt[PTR_W'(i)];
                    end else if (!have1 && (tgt[PTR_W'(i)] != tgt0 || tgt0 == '0)) begin
                        grant1[PTR_W'(i)] = 1'b1;
                        have1             = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/thor2024_rfwr_arb.sv
// Shares two register-file write ports among NREQ writeback requesters, round-robin.
// Define THOR2024_RFWR_STATS_EN to add saturating grant/conflict counters.
module thor2024_rfwr_arb
    import thor2024_rfwr_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_v,
    input  reg_idx_t [NREQ-1:0] req_tgt,
    input  value_t [NREQ-1:0]   req_bus,
    output logic [NREQ-1:0]     req_rdy,
    input  logic                rf_stall,
    output logic                commit0_v,
    output logic                commit1_v,
    output reg_idx_t            commit0_tgt,
    output reg_idx_t            commit1_tgt,
    output value_t              commit0_bus,
    output value_t              commit1_bus
`ifdef THOR2024_RFWR_STATS_EN
    ,
    output logic [31:0]         stat_grants,
    output logic [31:0]         stat_conflicts
`endif
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] ptr_next;
    logic [NREQ-1:0]  grant0;
    logic [NREQ-1:0]  grant1;
    logic             fire0;
    logic             fire1;
    reg_idx_t         tgt_sel0;
    reg_idx_t         tgt_sel1;
    value_t           bus_sel0;
    value_t           bus_sel1;

    thor2024_rfwr_arb_rr_pick2 #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid  (req_v),
        .tgt    (req_tgt),
        .rr_ptr (rr_ptr),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign fire0   = (|grant0) && !rf_stall && !rst;
    assign fire1   = (|grant1) && !rf_stall && !rst;
    assign req_rdy = (rf_stall || rst) ? '0 : (grant0 | grant1);

    // Port 1 always lies later in scan order than port 0, so its index wins for the pointer.
    always_comb begin
        last_idx = '0;
        tgt_sel0 = '0;
        tgt_sel1 = '0;
        bus_sel0 = '0;
        bus_sel1 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant0[PTR_W'(i)]) begin
                last_idx = PTR_W'(i);
                tgt_sel0 = req_tgt[PTR_W'(i)];
                bus_sel0 = req_bus[PTR_W'(i)];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant1[PTR_W'(i)]) begin
                last_idx = PTR_W'(i);
                tgt_sel1 = req_tgt[PTR_W'(i)];
                bus_sel1 = req_bus[PTR_W'(i)];
            end
        end
        ptr_next = (last_idx == PTR_W'(NREQ - 1)) ? '0 : last_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            commit0_v   <= 1'b0;
            commit1_v   <= 1'b0;
            commit0_tgt <= '0;
            commit1_tgt <= '0;
            commit0_bus <= '0;
            commit1_bus <= '0;
        end else begin
            // Target 0 is a discard: the grant is consumed but no write is issued.
            commit0_v <= fire0 && tgt_sel0 != '0;
            commit1_v <= fire1 && tgt_sel1 != '0;
            if (fire0) begin
                commit0_tgt <= tgt_sel0;
                commit0_bus <= bus_sel0;
                rr_ptr      <= ptr_next;
            end
            if (fire1) begin
                commit1_tgt <= tgt_sel1;
                commit1_bus <= bus_sel1;
            end
        end
    end

`ifdef THOR2024_RFWR_STATS_EN
    logic [32:0] grants_sum;
    logic        conflict;

    assign grants_sum = {1'b0, stat_grants} + 33'({1'b0, fire0} + {1'b0, fire1});
    assign conflict   = |(req_v & ~req_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            stat_grants <= grants_sum[32] ? '1 : grants_sum[31:0];
            if (conflict && stat_conflicts != '1) begin
                stat_conflicts <= stat_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_thor2024_rfwr_arb.sv
// Randomized bench for thor2024_rfwr_arb against a scan-order reference model,
// plus literal expectations for the directed scenarios.
module tb_thor2024_rfwr_arb;
    import thor2024_rfwr_arb_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  rf_stall = 1'b0;
    logic [N-1:0]          req_v = '0;
    logic [N-1:0][5:0]     req_tgt = '0;
    logic [N-1:0][63:0]    req_bus = '0;
    logic [N-1:0]          req_rdy;
    logic                  commit0_v, commit1_v;
    logic [5:0]            commit0_tgt, commit1_tgt;
    logic [63:0]           commit0_bus, commit1_bus;
`ifdef THOR2024_RFWR_STATS_EN
    logic [31:0]           stat_grants, stat_conflicts;
    int                    s_grants, s_conflicts;
`endif

    thor2024_rfwr_arb #(.NREQ(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_v       (req_v),
        .req_tgt     (req_tgt),
        .req_bus     (req_bus),
        .req_rdy     (req_rdy),
        .rf_stall    (rf_stall),
        .commit0_v   (commit0_v),
        .commit1_v   (commit1_v),
        .commit0_tgt (commit0_tgt),
        .commit1_tgt (commit1_tgt),
        .commit0_bus (commit0_bus),
        .commit1_bus (commit1_bus)
`ifdef THOR2024_RFWR_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int           errors = 0;
    int           checks = 0;
    int           m_ptr = 0;
    logic [N-1:0] m_rdy;
    logic         e_v0 = 1'b0, e_v1 = 1'b0, e_zero = 1'b1;
    logic [5:0]   e_t0 = '0, e_t1 = '0;
    logic [63:0]  e_b0 = '0, e_b1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: check registered outputs, apply inputs, check grants, advance model.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0][5:0] t,
                       input logic [N-1:0][63:0] b, input logic stall, input logic r);
        int g0, g1, idx, ng;
        @(negedge clk);
        chk("commit0_v", commit0_v, e_v0);
        chk("commit1_v", commit1_v, e_v1);
        if (e_v0 || e_zero) begin
            chk("commit0_tgt", commit0_tgt, e_t0);
            chk("commit0_bus", commit0_bus, e_b0);
        end
        if (e_v1 || e_zero) begin
            chk("commit1_tgt", commit1_tgt, e_t1);
            chk("commit1_bus", commit1_bus, e_b1);
        end
        chk("rr_ptr", dut.rr_ptr, m_ptr);
`ifdef THOR2024_RFWR_STATS_EN
        chk("stat_grants", stat_grants, s_grants);
        chk("stat_conflicts", stat_conflicts, s_conflicts);
`endif
        req_v = v; req_tgt = t; req_bus = b; rf_stall = stall; rst = r;
        #1;
        g0 = -1; g1 = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (v[idx]) begin
                if (g0 < 0) g0 = idx;
                else if (g1 < 0 && (t[idx] != t[g0] || t[g0] == 0)) g1 = idx;
            end
        end
        m_rdy = '0;
        if (!stall && !r) begin
            if (g0 >= 0) m_rdy[g0] = 1'b1;
            if (g1 >= 0) m_rdy[g1] = 1'b1;
        end
        chk("req_rdy", req_rdy, m_rdy);
        if (r) begin
            e_v0 = 0; e_v1 = 0; e_t0 = 0; e_t1 = 0; e_b0 = 0; e_b1 = 0;
            e_zero = 1; m_ptr = 0;
`ifdef THOR2024_RFWR_STATS_EN
            s_grants = 0; s_conflicts = 0;
`endif
        end else begin
            e_zero = 0; e_v0 = 0; e_v1 = 0; ng = 0;
            if (m_rdy != '0) begin
                e_v0 = (t[g0] != 0); e_t0 = t[g0]; e_b0 = b[g0]; ng = 1;
                if (g1 >= 0) begin
                    e_v1 = (t[g1] != 0); e_t1 = t[g1]; e_b1 = b[g1]; ng = 2;
                end
                m_ptr = ((g1 >= 0 ? g1 : g0) + 1) % N;
            end
`ifdef THOR2024_RFWR_STATS_EN
            s_grants += ng;
            if ((v & ~m_rdy) != '0) s_conflicts++;
`endif
        end
    endtask

    logic [N-1:0][5:0]  t1234, t55, t00, t7, rt;
    logic [N-1:0][63:0] bd, rb;

    initial begin
        t1234 = {6'd4, 6'd3, 6'd2, 6'd1};
        t55   = {6'd0, 6'd0, 6'd5, 6'd5};
        t00   = '0;
        t7    = {6'd0, 6'd0, 6'd0, 6'd7};
        bd    = {64'hD3, 64'hD2, 64'hB, 64'hA};
        repeat (2) @(posedge clk);

        // Reset release, idle
        cyc('0, t00, bd, 0, 0);
        chk("lit_idle_rdy", req_rdy, 4'b0000);
        cyc('0, t00, bd, 0, 0);
        chk("lit_idle_c0v", commit0_v, 1'b0);
        chk("lit_idle_c1v", commit1_v, 1'b0);

        // Four distinct targets: pairs granted in rotation
        cyc(4'b1111, t1234, bd, 0, 0);
        chk("lit_1234_rdy0", req_rdy, 4'b0011);
        cyc(4'b1111, t1234, bd, 0, 0);
        chk("lit_1234_c0v", commit0_v, 1'b1);
        chk("lit_1234_c0t", commit0_tgt, 6'd1);
        chk("lit_1234_c0b", commit0_bus, 64'hA);
        chk("lit_1234_c1t", commit1_tgt, 6'd2);
        chk("lit_1234_c1b", commit1_bus, 64'hB);
        chk("lit_1234_ptr", dut.rr_ptr, 2);
        chk("lit_1234_rdy1", req_rdy, 4'b1100);
        cyc('0, t1234, bd, 0, 0);
        chk("lit_1234_c0t2", commit0_tgt, 6'd3);
        chk("lit_1234_c1t2", commit1_tgt, 6'd4);

        // Same-target collision
        cyc('0, t00, bd, 0, 1);
        cyc(4'b0011, t55, bd, 0, 0);
        chk("lit_same_rdy0", req_rdy, 4'b0001);
        cyc(4'b0011, t55, bd, 0, 0);
        chk("lit_same_c0v", commit0_v, 1'b1);
        chk("lit_same_c0t", commit0_tgt, 6'd5);
        chk("lit_same_c0b", commit0_bus, 64'hA);
        chk("lit_same_c1v", commit1_v, 1'b0);
        chk("lit_same_rdy1", req_rdy, 4'b0010);
        cyc('0, t55, bd, 0, 0);
        chk("lit_same_c0b2", commit0_bus, 64'hB);

        // Target-0 discard, then two target-0 requesters together
        cyc('0, t00, bd, 0, 1);
        cyc(4'b0001, t00, bd, 0, 0);
        chk("lit_t0_rdy", req_rdy, 4'b0001);
        cyc(4'b0011, t00, bd, 0, 0);
        chk("lit_t0_c0v", commit0_v, 1'b0);
        chk("lit_t0pair_rdy", req_rdy, 4'b0011);
        cyc('0, t00, bd, 0, 0);
        chk("lit_t0pair_c0v", commit0_v, 1'b0);
        chk("lit_t0pair_c1v", commit1_v, 1'b0);

        // Stall blocks grants and holds the pointer
        cyc('0, t00, bd, 0, 1);
        repeat (3) begin
            cyc(4'b1111, t1234, bd, 1, 0);
            chk("lit_stall_rdy", req_rdy, 4'b0000);
        end
        cyc(4'b1111, t1234, bd, 0, 0);
        chk("lit_stall_ptr", dut.rr_ptr, 0);
        chk("lit_resume_rdy", req_rdy, 4'b0011);

        // Reset right after a grant discards it
        cyc(4'b0001, t7, bd, 0, 0);
        cyc('0, t7, bd, 0, 1);
        cyc('0, t7, bd, 0, 1);
        chk("lit_rst_c0v", commit0_v, 1'b0);
        cyc('0, t7, bd, 0, 0);
        chk("lit_post_rst_c0v", commit0_v, 1'b0);
        chk("lit_post_rst_c1v", commit1_v, 1'b0);
`ifdef THOR2024_RFWR_STATS_EN
        chk("lit_post_rst_stat", stat_grants, 32'd0);
`endif

        // Randomized traffic with frequent target collisions
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < N; i++) begin
                rt[i] = 6'($urandom_range(0, 3));
                rb[i] = {$urandom, $urandom};
            end
            cyc(N'($urandom), rt, rb, $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
        end
        cyc('0, t00, bd, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
